// File: rtl/tdm_demux1x4_if.sv
// rtl/tdm_demux1x4_if.sv - serial TDM stream in, rebuilt four-channel frame out
interface tdm_demux1x4_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sof;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [1:0]       slot;
  logic             frame_valid;
  logic             locked;
  logic             sync_err;

  modport master (
    output din, din_valid, sof,
    input  a, b, c, d, slot, frame_valid, locked, sync_err
  );

  modport slave (
    input  din, din_valid, sof,
    output a, b, c, d, slot, frame_valid, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux1x4.sv
// rtl/tdm_demux1x4.sv - 1:4 TDM demux with sof-based frame alignment
module tdm_demux1x4 #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux1x4_if.slave bus
);
  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t           state;
  logic [1:0]       slot_q;
  logic [WIDTH-1:0] stage0, stage1, stage2;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic             frame_valid_q, sync_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= UNLOCKED;
      slot_q        <= 2'd0;
      stage0        <= '0;
      stage1        <= '0;
      stage2        <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (bus.din_valid) begin
        case (state)
          UNLOCKED: begin
            if (bus.sof) begin
              stage0 <= bus.din;
              slot_q <= 2'd1;
              state  <= LOCKED;
            end
          end
          LOCKED: begin
            if (slot_q == 2'd0) begin
              if (bus.sof) begin
                stage0 <= bus.din;
                slot_q <= 2'd1;
              end else begin
                sync_err_q <= 1'b1;
                state      <= UNLOCKED;
                slot_q     <= 2'd0;
              end
            end else if (bus.sof) begin
              // Early sof restarts the frame; the partial one is abandoned.
              sync_err_q <= 1'b1;
              stage0     <= bus.din;
              slot_q     <= 2'd1;
            end else if (slot_q == 2'd3) begin
              a_q           <= stage0;
              b_q           <= stage1;
              c_q           <= stage2;
              d_q           <= bus.din;
              frame_valid_q <= 1'b1;
              slot_q        <= 2'd0;
            end else begin
              if (slot_q == 2'd1) stage1 <= bus.din;
              else                stage2 <= bus.din;
              slot_q <= slot_q + 2'd1;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.c           = c_q;
  assign bus.d           = d_q;
  assign bus.slot        = slot_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.locked      = (state == LOCKED);
endmodule

// File: tb/tb_tdm_demux1x4.sv
// tb/tb_tdm_demux1x4.sv - randomized and directed bench for tdm_demux1x4
module tb_tdm_demux1x4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  tdm_demux1x4_if #(.WIDTH(8)) bus ();

  tdm_demux1x4 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: the partial frame is a queue; its length is the expected slot.
  logic [7:0] q[$];
  logic [7:0] m_a = 8'h00, m_b = 8'h00, m_c = 8'h00, m_d = 8'h00;
  bit         m_locked = 1'b0, m_fv = 1'b0, m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_a = 8'h00; m_b = 8'h00; m_c = 8'h00; m_d = 8'h00;
      m_locked = 1'b0; m_fv = 1'b0; m_err = 1'b0;
    end else begin
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (bus.din_valid) begin
        if (!m_locked) begin
          if (bus.sof) begin
            m_locked = 1'b1;
            q.delete();
            q.push_back(bus.din);
          end
        end else if (bus.sof) begin
          if (q.size() != 0) m_err = 1'b1;
          q.delete();
          q.push_back(bus.din);
        end else if (q.size() == 0) begin
          m_err    = 1'b1;
          m_locked = 1'b0;
        end else begin
          q.push_back(bus.din);
          if (q.size() == 4) begin
            m_a = q[0]; m_b = q[1]; m_c = q[2]; m_d = q[3];
            m_fv = 1'b1;
            q.delete();
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a", bus.a, m_a);
    chk("b", bus.b, m_b);
    chk("c", bus.c, m_c);
    chk("d", bus.d, m_d);
    chk("slot", bus.slot, q.size());
    chk("frame_valid", bus.frame_valid, m_fv);
    chk("sync_err", bus.sync_err, m_err);
    chk("locked", bus.locked, m_locked);
  end

  task automatic beat(input logic [7:0] v, input logic s);
    @(negedge clk);
    bus.din_valid = 1'b1;
    bus.din       = v;
    bus.sof       = s;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.din_valid = 1'b0;
      bus.din       = 8'($urandom);
      bus.sof       = 1'($urandom);
    end
  endtask

  task automatic frame4(input logic [31:0] f, input string name);
    beat(f[31:24], 1'b1);
    beat(f[23:16], 1'b0);
    beat(f[15:8], 1'b0);
    beat(f[7:0], 1'b0);
    chk({name, "_abcd"}, {bus.a, bus.b, bus.c, bus.d}, f);
    chk({name, "_fv"}, bus.frame_valid, 1'b1);
  endtask

  initial begin
    bus.din = 8'h00; bus.din_valid = 1'b0; bus.sof = 1'b0;
    // Inputs toggle while reset is held.
    repeat (6) begin
      @(negedge clk);
      bus.din = 8'($urandom); bus.sof = 1'($urandom); bus.din_valid = 1'($urandom);
    end
    chk("rst_locked", bus.locked, 1'b0);
    chk("rst_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'h0);
    @(negedge clk);
    bus.din_valid = 1'b0;
    rst_n = 1'b1;

    // Aligned frame, then a back-to-back one.
    beat(8'h11, 1'b1);
    chk("align_locked", bus.locked, 1'b1);
    chk("align_slot", bus.slot, 2'd1);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    beat(8'h44, 1'b0);
    chk("align_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'h11223344);
    chk("align_fv", bus.frame_valid, 1'b1);
    frame4(32'hA0A1A2A3, "b2b");

    // Gapped input.
    beat(8'h11, 1'b1); gap(2);
    chk("gap_slot", bus.slot, 2'd1);
    beat(8'h22, 1'b0); gap(2);
    beat(8'h33, 1'b0); gap(2);
    chk("gap_nofv", bus.frame_valid, 1'b0);
    beat(8'h44, 1'b0);
    chk("gap_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'h11223344);
    chk("gap_fv", bus.frame_valid, 1'b1);

    // Early sof.
    beat(8'h55, 1'b1);
    beat(8'h66, 1'b0);
    beat(8'h77, 1'b1);
    chk("early_err", bus.sync_err, 1'b1);
    chk("early_hold", {bus.a, bus.b, bus.c, bus.d}, 32'h11223344);
    beat(8'h88, 1'b0);
    beat(8'h99, 1'b0);
    beat(8'hAA, 1'b0);
    chk("early_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'h778899AA);

    // Missing sof at slot 0.
    beat(8'h12, 1'b0);
    chk("miss_err", bus.sync_err, 1'b1);
    chk("miss_locked", bus.locked, 1'b0);
    beat(8'h34, 1'b0);
    chk("miss_quiet1", bus.sync_err, 1'b0);
    beat(8'h56, 1'b0);
    chk("miss_quiet2", bus.sync_err, 1'b0);
    frame4(32'h01020304, "relock");

    // Asynchronous reset mid-frame, asserted between edges.
    beat(8'hDE, 1'b1);
    beat(8'hAD, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'h0);
    chk("arst_locked", bus.locked, 1'b0);
    chk("arst_slot", bus.slot, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(8'hBE, 1'b0);
    chk("arst_nofv1", bus.frame_valid, 1'b0);
    beat(8'hEF, 1'b0);
    chk("arst_nofv2", bus.frame_valid, 1'b0);

    // Random traffic, sof biased towards the expected slot-0 position.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.din_valid = ($urandom_range(0, 3) != 0);
      bus.din       = 8'($urandom);
      bus.sof       = (q.size() == 0) ? ($urandom_range(0, 7) != 0)
                                      : ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    bus.din_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
